// File: rtl/ascii_streamer.sv
// ascii_streamer: captures a message of up to MAX_CHARS bytes and streams it one byte per
// cycle. Each message is followed by a GAP_CYCLES quiet interval, and done pulses in the
// last cycle of that interval.
// Optional build macro ASCII_STREAMER_TRIM_EN: trailing 8'h20/8'h00 bytes inside the
// requested length are dropped from the effective length at acceptance.
module ascii_streamer #(
    parameter int unsigned MAX_CHARS  = 16,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [8*MAX_CHARS-1:0]         string_in,
    input  logic [$clog2(MAX_CHARS+1)-1:0] length,
    input  logic                           start,
    input  logic                           abort,
    output logic [7:0]                     ascii_data,
    output logic                           ascii_data_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned LenW = $clog2(MAX_CHARS + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    // A zero-length gap still occupies one GAP cycle.
    localparam logic [GapW-1:0] GapLast = (GAP_CYCLES == 0) ? '0 : GapW'(GAP_CYCLES - 1);
    localparam logic [LenW-1:0] MaxLen  = LenW'(MAX_CHARS);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e                 state_q, state_d;
    logic [8*MAX_CHARS-1:0] buf_q, buf_d;
    logic [LenW-1:0]        len_q, len_d;
    logic [LenW-1:0]        idx_q, idx_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic [7:0]             data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [LenW-1:0]        clamp_len;
    logic [LenW-1:0]        eff_len;
    logic [LenW-1:0]        idx_next;

    // Character 0 lives in the most-significant byte.
    function automatic logic [7:0] char_at(input logic [8*MAX_CHARS-1:0] s,
                                           input logic [LenW-1:0] idx);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < int'(MAX_CHARS); i++) begin
            if (LenW'(i) == idx) begin
                c = s[8*(int'(MAX_CHARS)-1-i) +: 8];
            end
        end
        return c;
    endfunction

    // Effective length seen at acceptance: clamp, then optionally trim trailing padding.
    always_comb begin
        clamp_len = (length > MaxLen) ? MaxLen : length;
`ifdef ASCII_STREAMER_TRIM_EN
        eff_len = '0;
        for (int i = 0; i < int'(MAX_CHARS); i++) begin
            if ((LenW'(i) < clamp_len) &&
                (string_in[8*(int'(MAX_CHARS)-1-i) +: 8] != 8'h20) &&
                (string_in[8*(int'(MAX_CHARS)-1-i) +: 8] != 8'h00)) begin
                eff_len = LenW'(i + 1);
            end
        end
`else
        eff_len = clamp_len;
`endif
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        len_d    = len_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        data_d   = 8'h00;
        ready_d  = 1'b0;
        idx_next = idx_q + LenW'(1);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    buf_d = string_in;
                    len_d = eff_len;
                    idx_d = '0;
                    gap_d = '0;
                    if (eff_len != '0) begin
                        state_d = StSend;
                        data_d  = char_at(string_in, '0);
                        ready_d = 1'b1;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StSend: begin
                if (abort || (idx_next >= len_q)) begin
                    state_d = StGap;
                    gap_d   = '0;
                end else begin
                    idx_d   = idx_next;
                    data_d  = char_at(buf_q, idx_next);
                    ready_d = 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StGap) && (gap_d == GapLast);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            buf_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ascii_data       = data_q;
    assign ascii_data_ready = ready_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_ascii_streamer.sv
// tb_ascii_streamer: scoreboard bench for ascii_streamer. Expected bytes are queued when a
// message is launched and popped by a negedge monitor whenever ascii_data_ready is high.
module tb_ascii_streamer;

    localparam int MaxChars  = 16;
    localparam int GapCycles = 4;
    localparam int LenW      = $clog2(MaxChars + 1);

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [8*MaxChars-1:0] string_in = '0;
    logic [LenW-1:0]       length = '0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [7:0]            ascii_data;
    logic                  ascii_data_ready;
    logic                  busy;
    logic                  done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;

    ascii_streamer #(
        .MAX_CHARS (MaxChars),
        .GAP_CYCLES(GapCycles)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .string_in       (string_in),
        .length          (length),
        .start           (start),
        .abort           (abort),
        .ascii_data      (ascii_data),
        .ascii_data_ready(ascii_data_ready),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Number of bytes a message should produce.
    function automatic int model_len(input logic [8*MaxChars-1:0] s, input int len);
        int n;
        n = (len > MaxChars) ? MaxChars : len;
`ifdef ASCII_STREAMER_TRIM_EN
        while (n > 0 && (s[8*(MaxChars-n) +: 8] == 8'h20 || s[8*(MaxChars-n) +: 8] == 8'h00))
            n--;
`endif
        return n;
    endfunction

    task automatic push_msg(input logic [8*MaxChars-1:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s[8*(MaxChars-1-i) +: 8]);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (ascii_data_ready) begin
                if (exp_q.size() == 0) check_val("unexpected_byte", ascii_data_ready, 0);
                else check_val("byte", ascii_data, exp_q.pop_front());
            end else begin
                check_val("idle_data", ascii_data, 8'h00);
            end
        end
    end

    task automatic launch(input logic [8*MaxChars-1:0] s, input int len, input int n_exp);
        @(negedge clk);
        string_in = s;
        length    = LenW'(len);
        start     = 1'b1;
        push_msg(s, n_exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Samples cycles N+1, N+2, ... until done or budget; optionally pulses abort.
    task automatic measure(input int abort_at, output int first_k, output int last_k,
                           output int n_ready, output int done_k, output int n_busy);
        first_k = -1; last_k = -1; n_ready = 0; done_k = -1; n_busy = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (ascii_data_ready) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                n_ready++;
            end
            if (busy) n_busy++;
            abort = (k == abort_at);
            if (done) begin
                done_k = k;
                break;
            end
        end
        abort = 1'b0;
    endtask

    task automatic run_check(input logic [8*MaxChars-1:0] s, input int len, input int abort_at);
        int n, first_k, last_k, n_ready, done_k, n_busy;
        n = model_len(s, len);
        if (abort_at > 0 && abort_at < n) n = abort_at;
        launch(s, len, n);
        measure(abort_at, first_k, last_k, n_ready, done_k, n_busy);
        if (n > 0) begin
            check_val("first_ready_cycle", first_k, 1);
            check_val("last_ready_cycle", last_k, n);
        end
        check_val("ready_count", n_ready, n);
        check_val("done_cycle", done_k, n + GapCycles);
        check_val("busy_cycles", n_busy, n + GapCycles);
        @(negedge clk);
        check_val("busy_after_done", busy, 0);
        check_val("done_single_pulse", done, 0);
        check_val("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [8*MaxChars-1:0] s;
        int nr, first2, done_k, first_k, last_k, n_ready, n_busy;

        // Reset state.
        #12;
        check_val("rst_data", ascii_data, 8'h00);
        check_val("rst_ready", ascii_data_ready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        run_check("HELLO WORLD     ", 16, 0);
        run_check('0, 0, 0);
        run_check("                ", 16, 0);
        run_check("ABCDEFGHIJKLMNOP", 20, 0);
        run_check("0123456789abcdef", 16, 3);
        s = {8'h5A, 120'h0};
        run_check(s, 1, 0);

        // start held high throughout; buffer must not be recaptured while busy.
        @(negedge clk);
        string_in = {32'hDEADBEEF, 96'h0};
        length    = LenW'(4);
        start     = 1'b1;
        push_msg(string_in, 4);
        @(posedge clk);
        #1;
        string_in = {16'h5859, 112'h0};
        length    = LenW'(2);
        push_msg(string_in, 2);
        nr = 0; first2 = -1; done_k = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) done_k = k;
            if (ascii_data_ready) begin
                nr++;
                if (nr == 5) begin
                    first2 = k;
                    break;
                end
            end
        end
        start = 1'b0;
        check_val("spam_done_cycle", done_k, 4 + GapCycles);
        check_val("spam_restart_cycle", first2, 4 + GapCycles + 2);
        measure(0, first_k, last_k, n_ready, done_k, n_busy);
        check_val("spam_tail_ready", n_ready, 1);
        check_val("spam_tail_done", done_k, 1 + GapCycles);
        @(negedge clk);
        check_val("spam_queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of SEND.
        launch("RESETMIDMESSAGE!", 16, 5);
        for (int k = 1; k <= 5; k++) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_val("async_rst_ready", ascii_data_ready, 0);
        check_val("async_rst_data", ascii_data, 8'h00);
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_done", done, 0);
        check_val("async_rst_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s = {16'h4F4B, 112'h0};
        run_check(s, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
